// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, abort,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide on magnitudes,
// with sign correction in a final FIX cycle. MTHI/MTLO write HI/LO in one cycle.
module mult_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int W2 = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
        return en ? ((~v) + DATA_W'(1)) : v;
    endfunction

    function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v, input logic en);
        return en ? ((~v) + W2'(1)) : v;
    endfunction

    state_t              state_r, state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [W2-1:0]       acc_r;
    logic [DATA_W-1:0]   b_r, hi_r, lo_r;
    logic                is_div_r, neg_q_r, neg_r_r, div0_r, busy_r, done_r;

    logic                launch_s, mtxx_s, last_s;
    logic                rs_neg_s, rt_neg_s;
    logic [DATA_W-1:0]   rs_mag_s, rt_mag_s;
    logic [DATA_W:0]     mul_sum_s, rem_shift_s;
    logic [DATA_W+1:0]   diff_s;
    logic [W2-1:0]       mul_step_s, div_step_s, prod_s;
    logic [DATA_W-1:0]   quot_s, rem_s;

    assign launch_s = (state_r == ST_IDLE) && bus.start && !bus.abort && !bus.op[2];
    assign mtxx_s   = (state_r == ST_IDLE) && bus.start && !bus.abort && (bus.op[2:1] == 2'b10);
    assign last_s   = (cnt_r == CNT_W'(DATA_W - 1));

    // Signed ops (op[0]==0) iterate on magnitudes; signs are re-applied in FIX.
    assign rs_neg_s = !bus.op[0] && bus.rs_val[DATA_W-1];
    assign rt_neg_s = !bus.op[0] && bus.rt_val[DATA_W-1];
    assign rs_mag_s = neg_w(bus.rs_val, rs_neg_s);
    assign rt_mag_s = neg_w(bus.rt_val, rt_neg_s);

    // Multiply: low half of acc holds the multiplier being consumed LSB first.
    assign mul_sum_s  = {1'b0, acc_r[W2-1:DATA_W]} + (acc_r[0] ? {1'b0, b_r} : {(DATA_W+1){1'b0}});
    assign mul_step_s = {mul_sum_s, acc_r[DATA_W-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign rem_shift_s = {acc_r[W2-1:DATA_W], acc_r[DATA_W-1]};
    assign diff_s      = {1'b0, rem_shift_s} - {2'b00, b_r};
    assign div_step_s  = diff_s[DATA_W+1] ? {rem_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0}
                                          : {diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};

    // With a zero divisor the remainder ends up equal to the dividend, so only LO needs forcing.
    assign prod_s = neg_w2(acc_r, neg_q_r);
    assign quot_s = div0_r ? {DATA_W{1'b1}} : neg_w(acc_r[DATA_W-1:0], neg_q_r);
    assign rem_s  = neg_w(acc_r[W2-1:DATA_W], neg_r_r);

    // Next-state logic; abort returns to IDLE from any busy state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_nx_s = ST_CALC;
                else          state_nx_s = ST_IDLE;
            end
            ST_CALC: begin
                if (bus.abort)   state_nx_s = ST_IDLE;
                else if (last_s) state_nx_s = ST_FIX;
                else             state_nx_s = ST_CALC;
            end
            ST_FIX:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Operand latch, iteration datapath, HI/LO writeback and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {W2{1'b0}};
            b_r      <= {DATA_W{1'b0}};
            hi_r     <= {DATA_W{1'b0}};
            lo_r     <= {DATA_W{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        acc_r    <= {{DATA_W{1'b0}}, (bus.op[1] ? rs_mag_s : rt_mag_s)};
                        b_r      <= bus.op[1] ? rt_mag_s : rs_mag_s;
                        is_div_r <= bus.op[1];
                        neg_q_r  <= rs_neg_s ^ rt_neg_s;
                        neg_r_r  <= rs_neg_s;
                        div0_r   <= bus.op[1] && (bus.rt_val == {DATA_W{1'b0}});
                        cnt_r    <= {CNT_W{1'b0}};
                    end else if (mtxx_s) begin
                        if (bus.op[0]) lo_r <= bus.rs_val;
                        else           hi_r <= bus.rs_val;
                    end
                end
                ST_CALC: begin
                    if (!bus.abort) begin
                        acc_r <= is_div_r ? div_step_s : mul_step_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.abort) begin
                        if (is_div_r) begin
                            hi_r <= rem_s;
                            lo_r <= quot_s;
                        end else begin
                            hi_r <= prod_s[W2-1:DATA_W];
                            lo_r <= prod_s[DATA_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_r == ST_FIX) && !bus.abort;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: HI/LO moves, mult/div results and latency, abort, reset.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mult_div_unit_if #(.DATA_W(32)) bus ();

    mult_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = 64'h0;
        case (op)
            3'b000: res = sa * sb;
            3'b001: res = ua * ub;
            3'b010: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'b011: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    res[31:0]  = 32'(ua / ub);
                    res[63:32] = 32'(ua % ub);
                end
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    // Launch one mult/div, optionally re-pulse start mid-op, and check latency and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit repulse);
        int k;
        int busy_cyc;
        bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
        tick();
        bus.start = 1'b0; bus.rs_val = 32'h0; bus.rt_val = 32'h0;
        k = 0;
        busy_cyc = 0;
        while (k < 40 && !bus.done) begin
            if (bus.busy) busy_cyc++;
            if (repulse && k == 5) begin
                bus.start = 1'b1; bus.op = 3'b001; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            k++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        tick();
        check({tag, "_done_width"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          seen;

        bus.start = 1'b0; bus.op = 3'b000; bus.rs_val = 32'h0; bus.rt_val = 32'h0; bus.abort = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);

        bus.start = 1'b1; bus.op = 3'b100; bus.rs_val = 32'h0000_1234;
        tick();
        check("mthi_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_0000);
        bus.op = 3'b101; bus.rs_val = 32'h0000_ABCD;
        tick();
        bus.start = 1'b0;
        check("mtlo_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_ABCD);
        check("mtxx_busy", 64'(bus.busy), 64'd0);
        check("mtxx_done", 64'(bus.done), 64'd0);

        run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("divu", 3'b011, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op("divu_zero", 3'b011, 32'd55, 32'd0, 64'h0000_0037_FFFF_FFFF, 1'b1);
        run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF7, 32'd0, 64'hFFFF_FFF7_FFFF_FFFF, 1'b0);

        // Abort in the tenth CALC cycle.
        prev = {bus.hi, bus.lo};
        bus.start = 1'b1; bus.op = 3'b000; bus.rs_val = 32'd5; bus.rt_val = 32'd6;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_calc_busy", 64'(bus.busy), 64'd0);
        check("abort_calc_hilo", {bus.hi, bus.lo}, prev);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            tick();
        end
        check("abort_calc_no_done", 64'(seen), 64'd0);

        // Abort coinciding with the FIX writeback edge.
        bus.start = 1'b1; bus.op = 3'b001; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        check("pre_fix_busy", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_fix_done", 64'(bus.done), 64'd0);
        check("abort_fix_busy", 64'(bus.busy), 64'd0);
        check("abort_fix_hilo", {bus.hi, bus.lo}, prev);

        // Abort alongside MTHI in IDLE, then a no-op encoding.
        bus.start = 1'b1; bus.abort = 1'b1; bus.op = 3'b100; bus.rs_val = 32'hDEAD_BEEF;
        tick();
        bus.abort = 1'b0; bus.op = 3'b110;
        tick();
        bus.op = 3'b111;
        tick();
        bus.start = 1'b0;
        check("idle_abort_nop_hilo", {bus.hi, bus.lo}, prev);
        check("idle_abort_nop_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of an operation.
        bus.start = 1'b1; bus.op = 3'b001; bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midop_reset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("midop_reset_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) seen++;
            tick();
        end
        check("midop_reset_quiet", 64'(seen), 64'd0);

        // Pseudo-random sweep against the arithmetic reference model.
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 4 == 3) rb = (~rb) + 32'd1;
            run_op("sweep", rop, ra, rb, ref_model(rop, ra, rb), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
